// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4-lane TDM link.
// Collects lane words A, B, C, D (lane 0 marked by in_sof) and presents each
// finished frame in parallel through a ready/valid output register. A fourth
// assembly register lets one complete frame wait behind a stalled output.

module tdm_demux4 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [DATA_WIDTH-1:0] out_c,
  output logic [DATA_WIDTH-1:0] out_d,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            lane,
  output logic                  frame_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                state_r, nextState_s;
  logic [1:0]            lane_r, nextLane_s;
  logic [DATA_WIDTH-1:0] asm0_r, asm1_r, asm2_r, asm3_r;
  logic [DATA_WIDTH-1:0] nextAsm0_s, nextAsm1_s, nextAsm2_s, nextAsm3_s;
  logic [DATA_WIDTH-1:0] outA_r, outB_r, outC_r, outD_r;
  logic [DATA_WIDTH-1:0] nextOutA_s, nextOutB_s, nextOutC_s, nextOutD_s;
  logic                  outValid_r, nextOutValid_s;
  logic                  frameErr_r, nextFrameErr_s;
  logic                  accept_s;
  logic                  drain_s;
  logic                  outFree_s;
  logic                  loadFrame_s;

  // Input is only stalled while a finished frame waits in the assembly registers.
  assign in_ready  = (state_r != HOLD);
  assign accept_s  = in_valid & in_ready;
  assign drain_s   = outValid_r & out_ready;
  // Output register can take a new frame if empty or being drained this cycle.
  assign outFree_s = (~outValid_r) | out_ready;

  assign out_a     = outA_r;
  assign out_b     = outB_r;
  assign out_c     = outC_r;
  assign out_d     = outD_r;
  assign out_valid = outValid_r;
  assign lane      = lane_r;
  assign frame_err = frameErr_r;

  // Next-state, assembly and output-register update decisions.
  always_comb begin
    nextState_s    = state_r;
    nextLane_s     = lane_r;
    nextAsm0_s     = asm0_r;
    nextAsm1_s     = asm1_r;
    nextAsm2_s     = asm2_r;
    nextAsm3_s     = asm3_r;
    nextOutA_s     = outA_r;
    nextOutB_s     = outB_r;
    nextOutC_s     = outC_r;
    nextOutD_s     = outD_r;
    nextOutValid_s = outValid_r;
    nextFrameErr_s = 1'b0;
    loadFrame_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (in_sof) begin
            nextAsm0_s  = in_data;
            nextLane_s  = 2'd1;
            nextState_s = COLLECT;
          end else begin
            // Word outside any frame: drop it and flag the violation.
            nextFrameErr_s = 1'b1;
          end
        end else begin
          nextState_s = IDLE;
        end
      end

      COLLECT: begin
        if (accept_s) begin
          if (in_sof) begin
            // Early start-of-frame: abandon the partial frame, restart at lane 0.
            nextFrameErr_s = 1'b1;
            nextAsm0_s     = in_data;
            nextLane_s     = 2'd1;
          end else begin
            case (lane_r)
              2'd1: begin
                nextAsm1_s = in_data;
                nextLane_s = 2'd2;
              end
              2'd2: begin
                nextAsm2_s = in_data;
                nextLane_s = 2'd3;
              end
              2'd3: begin
                if (outFree_s) begin
                  nextOutA_s  = asm0_r;
                  nextOutB_s  = asm1_r;
                  nextOutC_s  = asm2_r;
                  nextOutD_s  = in_data;
                  loadFrame_s = 1'b1;
                  nextLane_s  = 2'd0;
                  nextState_s = IDLE;
                end else begin
                  // Output still occupied: park the last lane and stall input.
                  nextAsm3_s  = in_data;
                  nextLane_s  = 2'd0;
                  nextState_s = HOLD;
                end
              end
              default: begin
                // Lane 0 is never expected here without sof; resynchronise.
                nextFrameErr_s = 1'b1;
                nextLane_s     = 2'd0;
                nextState_s    = IDLE;
              end
            endcase
          end
        end else begin
          nextState_s = COLLECT;
        end
      end

      HOLD: begin
        if (drain_s) begin
          nextOutA_s  = asm0_r;
          nextOutB_s  = asm1_r;
          nextOutC_s  = asm2_r;
          nextOutD_s  = asm3_r;
          loadFrame_s = 1'b1;
          nextState_s = IDLE;
        end else begin
          nextState_s = HOLD;
        end
      end

      default: begin
        nextLane_s  = 2'd0;
        nextState_s = IDLE;
      end
    endcase

    // A load always wins over a simultaneous drain.
    if (loadFrame_s) begin
      nextOutValid_s = 1'b1;
    end else if (drain_s) begin
      nextOutValid_s = 1'b0;
    end else begin
      nextOutValid_s = outValid_r;
    end
  end

  // State, assembly and output registers; reset discards every held frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      lane_r     <= 2'd0;
      asm0_r     <= {DATA_WIDTH{1'b0}};
      asm1_r     <= {DATA_WIDTH{1'b0}};
      asm2_r     <= {DATA_WIDTH{1'b0}};
      asm3_r     <= {DATA_WIDTH{1'b0}};
      outA_r     <= {DATA_WIDTH{1'b0}};
      outB_r     <= {DATA_WIDTH{1'b0}};
      outC_r     <= {DATA_WIDTH{1'b0}};
      outD_r     <= {DATA_WIDTH{1'b0}};
      outValid_r <= 1'b0;
      frameErr_r <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      lane_r     <= nextLane_s;
      asm0_r     <= nextAsm0_s;
      asm1_r     <= nextAsm1_s;
      asm2_r     <= nextAsm2_s;
      asm3_r     <= nextAsm3_s;
      outA_r     <= nextOutA_s;
      outB_r     <= nextOutB_s;
      outC_r     <= nextOutC_s;
      outD_r     <= nextOutD_s;
      outValid_r <= nextOutValid_s;
      frameErr_r <= nextFrameErr_s;
    end
  end

endmodule
